// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the ALU execute stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // ADD and SUB are the only opcodes that saturate and write all flags.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ALU_adder.sv
// Two's-complement adder/subtractor with signed-overflow detect and optional saturation.
module ALU_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  input  logic         i_sat,
  output logic [W-1:0] o_sum,
  output logic         o_ovfl
);

  logic [W-1:0] w_b;
  logic [W-1:0] w_raw;
  logic [W-1:0] w_max;
  logic [W-1:0] w_min;

  assign w_b   = i_sub ? ~i_b : i_b;
  assign w_raw = i_a + w_b + {{(W-1){1'b0}}, i_sub};
  assign w_max = {1'b0, {(W-1){1'b1}}};
  assign w_min = {1'b1, {(W-1){1'b0}}};

  // Overflow: operands (after inversion for subtract) agree in sign, result does not.
  assign o_ovfl = (i_a[W-1] == w_b[W-1]) && (w_raw[W-1] != i_a[W-1]);

  always_comb begin
    o_sum = w_raw;
    if (i_sat && o_ovfl) begin
      o_sum = i_a[W-1] ? w_min : w_max;
    end
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: single-entry result buffer in front of EX/MEM, computing ALU ops
// and address sums through one shared ALU_adder.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [3:0]        dst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_dst,
  output logic [2:0]        flags
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Upstream may not retract in_valid/op/operands on its own; ready never depends on
  // in_valid. Downstream sees out_* stable while out_valid & ~out_ready.

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_dst;
  logic [2:0]        r_flags;

  logic              w_accept;
  logic              w_sub;
  logic              w_sat;
  logic [DATA_W-1:0] w_sum;
  logic              w_ovfl;
  logic [DATA_W-1:0] w_result;
  logic [2:0]        w_flags_nxt;

  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;

  assign w_sub = (op == OP_SUB);
  assign w_sat = is_arith(op);

  ALU_adder #(.W(DATA_W)) u_adder (
    .i_a    (in1),
    .i_b    (in2),
    .i_sub  (w_sub),
    .i_sat  (w_sat),
    .o_sum  (w_sum),
    .o_ovfl (w_ovfl)
  );

  always_comb begin
    w_result    = in1;
    w_flags_nxt = r_flags;
    case (op)
      OP_ADD, OP_SUB: begin
        w_result            = w_sum;
        w_flags_nxt[FLAG_Z] = (w_sum == '0);
        w_flags_nxt[FLAG_V] = w_ovfl;
        w_flags_nxt[FLAG_N] = w_sum[DATA_W-1];
      end
      OP_XOR: begin
        w_result            = in1 ^ in2;
        w_flags_nxt[FLAG_Z] = ((in1 ^ in2) == '0);
      end
      OP_LW, OP_SW: begin
        w_result = w_sum;
      end
      default: begin
        w_result = in1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dst    <= 4'h0;
      r_flags  <= 3'b000;
    end else begin
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_result <= w_result;
        r_dst    <= dst;
        r_flags  <= w_flags_nxt;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_dst    = r_dst;
  assign flags      = r_flags;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: saturation, flags, handshake stall, flush, async reset.
module tb_alu_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [3:0]  dst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic [2:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  alu_ex_stage #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .in1        (in1),
    .in2        (in2),
    .dst        (dst),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dst    (out_dst),
    .flags      (flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d);
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
    dst      = d;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    op       = 4'hF;
    in1      = 16'hDEAD;
    in2      = 16'hBEEF;
    dst      = 4'hF;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; idle();
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", out_result); end
    n_tests++; if (out_dst !== 4'h0) begin n_fail++; $display("FAIL reset_dst got=%h exp=0", out_dst); end
    n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_sat;
    drive(4'h0, 16'h7000, 16'h2000, 4'h3);
    tick(); idle();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_sat_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_result !== 16'h7FFF) begin n_fail++; $display("FAIL add_sat_result got=%h exp=7fff", out_result); end
    n_tests++; if (out_dst !== 4'h3) begin n_fail++; $display("FAIL add_sat_dst got=%h exp=3", out_dst); end
    n_tests++; if (flags !== 3'b010) begin n_fail++; $display("FAIL add_sat_flags got=%b exp=010", flags); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain_valid got=%b exp=0", out_valid); end
    // negative saturation: 0x8000 + 0xFFFF -> 0x8000, V=1 N=1
    drive(4'h0, 16'h8000, 16'hFFFF, 4'h4);
    tick(); idle();
    n_tests++; if (out_result !== 16'h8000) begin n_fail++; $display("FAIL add_negsat_result got=%h exp=8000", out_result); end
    n_tests++; if (flags !== 3'b011) begin n_fail++; $display("FAIL add_negsat_flags got=%b exp=011", flags); end
    tick();
  endtask

  task automatic test_xor_retain;
    // flags are 011 here; XOR to zero sets Z and keeps V,N
    drive(4'h2, 16'h1234, 16'h1234, 4'h5);
    tick(); idle();
    n_tests++; if (out_result !== 16'h0000) begin n_fail++; $display("FAIL xor_zero_result got=%h exp=0000", out_result); end
    n_tests++; if (flags !== 3'b111) begin n_fail++; $display("FAIL xor_zero_flags got=%b exp=111", flags); end
    tick();
  endtask

  task automatic test_sub_xor;
    drive(4'h1, 16'h0005, 16'h0005, 4'h6);
    tick();
    n_tests++; if (out_result !== 16'h0000) begin n_fail++; $display("FAIL sub_zero_result got=%h exp=0000", out_result); end
    n_tests++; if (flags !== 3'b100) begin n_fail++; $display("FAIL sub_zero_flags got=%b exp=100", flags); end
    drive(4'h2, 16'h00F0, 16'h000F, 4'h7);
    tick(); idle();
    n_tests++; if (out_result !== 16'h00FF) begin n_fail++; $display("FAIL xor_result got=%h exp=00ff", out_result); end
    n_tests++; if (out_dst !== 4'h7) begin n_fail++; $display("FAIL xor_dst got=%h exp=7", out_dst); end
    n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL xor_flags got=%b exp=000", flags); end
    tick();
    // SUB overflow: 0x8000 - 0x0001 -> 0x8000 saturated, V=1 N=1
    drive(4'h1, 16'h8000, 16'h0001, 4'h8);
    tick(); idle();
    n_tests++; if (out_result !== 16'h8000) begin n_fail++; $display("FAIL sub_sat_result got=%h exp=8000", out_result); end
    n_tests++; if (flags !== 3'b011) begin n_fail++; $display("FAIL sub_sat_flags got=%b exp=011", flags); end
    tick();
  endtask

  task automatic test_addr_pass;
    // flags are 011 here and must not move
    drive(4'h8, 16'h1000, 16'h7FF0, 4'h9);
    tick();
    n_tests++; if (out_result !== 16'h8FF0) begin n_fail++; $display("FAIL lw_result got=%h exp=8ff0", out_result); end
    n_tests++; if (flags !== 3'b011) begin n_fail++; $display("FAIL lw_flags got=%b exp=011", flags); end
    drive(4'h9, 16'hFFFF, 16'h0002, 4'hA);
    tick();
    n_tests++; if (out_result !== 16'h0001) begin n_fail++; $display("FAIL sw_result got=%h exp=0001", out_result); end
    n_tests++; if (flags !== 3'b011) begin n_fail++; $display("FAIL sw_flags got=%b exp=011", flags); end
    drive(4'h5, 16'hABCD, 16'h1111, 4'hB);
    tick(); idle();
    n_tests++; if (out_result !== 16'hABCD) begin n_fail++; $display("FAIL pass_result got=%h exp=abcd", out_result); end
    n_tests++; if (out_dst !== 4'hB) begin n_fail++; $display("FAIL pass_dst got=%h exp=b", out_dst); end
    n_tests++; if (flags !== 3'b011) begin n_fail++; $display("FAIL pass_flags got=%b exp=011", flags); end
    tick();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(4'h0, 16'h0001, 16'h0002, 4'h1);
    tick();
    drive(4'h1, 16'h000A, 16'h0003, 4'h2);
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 16'h0003 || out_dst !== 4'h1) begin
      n_fail++; $display("FAIL stall_hold got=%b/%h/%h exp=1/0003/1", out_valid, out_result, out_dst);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_result !== 16'h0003) begin
      n_fail++; $display("FAIL release_comb got=%b/%h exp=1/0003", in_ready, out_result);
    end
    tick(); idle();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 16'h0007 || out_dst !== 4'h2) begin
      n_fail++; $display("FAIL second_result got=%b/%h/%h exp=1/0007/2", out_valid, out_result, out_dst);
    end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_duplicate got=%b exp=0", out_valid); end
    // full-rate stream with out_ready held high
    drive(4'h0, 16'h0010, 16'h0020, 4'h3); tick();
    n_tests++; if (out_result !== 16'h0030) begin n_fail++; $display("FAIL b2b_0 got=%h exp=0030", out_result); end
    drive(4'h2, 16'hFF00, 16'h0FF0, 4'h4); tick();
    n_tests++; if (out_result !== 16'hF0F0) begin n_fail++; $display("FAIL b2b_1 got=%h exp=f0f0", out_result); end
    drive(4'h8, 16'h0100, 16'h0023, 4'h5); tick(); idle();
    n_tests++; if (out_result !== 16'h0123 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_2 got=%b/%h exp=1/0123", out_valid, out_result);
    end
    tick();
  endtask

  task automatic test_flush;
    drive(4'h1, 16'h0005, 16'h0005, 4'h6); tick(); idle(); tick();
    n_tests++; if (flags !== 3'b100) begin n_fail++; $display("FAIL flush_pre_flags got=%b exp=100", flags); end
    flush = 1'b1;
    drive(4'h0, 16'h0001, 16'h0001, 4'h7);
    tick(); idle(); flush = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    n_tests++; if (flags !== 3'b100) begin n_fail++; $display("FAIL flush_flags got=%b exp=100", flags); end
    tick();
  endtask

  task automatic test_reset_mid_stall;
    out_ready = 1'b0;
    drive(4'h0, 16'h8000, 16'hFFFF, 4'hC);
    tick(); idle();
    n_tests++; if (out_valid !== 1'b1 || flags !== 3'b011) begin
      n_fail++; $display("FAIL pre_reset got=%b/%b exp=1/011", out_valid, flags);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
    n_tests++; if (flags !== 3'b000 || out_result !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_state got=%b/%h exp=000/0000", flags, out_result);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    drive(4'h2, 16'h0003, 16'h0001, 4'hD);
    tick(); idle();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 16'h0002 || flags !== 3'b000) begin
      n_fail++; $display("FAIL post_reset got=%b/%h/%b exp=1/0002/000", out_valid, out_result, flags);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_xor_retain();
    test_sub_xor();
    test_addr_pass();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
